// File: rtl/rob_cdb_arbiter_if.sv
// Completion-bus bundle: FU requests in, registered CDB entry out.
// master = FU/ROB side, slave = arbiter.
interface rob_cdb_arbiter_if #(
  parameter int NUM_FU = 4,
  parameter int TAG_W  = 5,
  parameter int DATA_W = 64
);
  localparam int SRC_W = $clog2(NUM_FU);

  logic [NUM_FU-1:0]        fu_valid;
  logic [NUM_FU-1:0]        fu_ready;
  logic [NUM_FU*TAG_W-1:0]  fu_tag;
  logic [NUM_FU*DATA_W-1:0] fu_data;
  logic [NUM_FU-1:0]        fu_exc;

  logic              cdb_valid;
  logic              cdb_ready;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              cdb_exc;
  logic [SRC_W-1:0]  cdb_src;

  modport master (
    output fu_valid, fu_tag, fu_data, fu_exc,
    output cdb_ready,
    input  fu_ready,
    input  cdb_valid, cdb_tag, cdb_data,
    input  cdb_exc, cdb_src
  );

  modport slave (
    input  fu_valid, fu_tag, fu_data, fu_exc,
    input  cdb_ready,
    output fu_ready,
    output cdb_valid, cdb_tag, cdb_data,
    output cdb_exc, cdb_src
  );
endinterface

// File: rtl/rob_cdb_arbiter.sv
// Round-robin FU completion arbiter onto a registered CDB entry.
// ROB_CDB_PERF_EN adds stall/conflict performance counters.
module rob_cdb_arbiter #(
  parameter int NUM_FU = 4,
  parameter int TAG_W  = 5,
  parameter int DATA_W = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic flush_i,
  rob_cdb_arbiter_if.slave bus
`ifdef ROB_CDB_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt_o,
  output logic [31:0] perf_conflict_cnt_o
`endif
);
  localparam int SRC_W = $clog2(NUM_FU);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e            state_q, state_d;
  logic [SRC_W-1:0]  rr_q, rr_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              exc_q, exc_d;
  logic [SRC_W-1:0]  src_q, src_d;

  logic              can_load;
  logic              req_hit;
  logic              gnt;
  logic [SRC_W-1:0]  gnt_idx;
  logic [NUM_FU-1:0] fu_ready_d;

  assign can_load = ~flush_i &
    ((state_q == EMPTY) | bus.cdb_ready);

  // Scan downward so the FU nearest rr_q wins.
  always_comb begin
    int idx;
    logic [SRC_W-1:0] sidx;
    req_hit = 1'b0;
    gnt_idx = '0;
    for (int k = NUM_FU - 1; k >= 0; k--) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      sidx = SRC_W'(idx);
      if (bus.fu_valid[sidx]) begin
        req_hit = 1'b1;
        gnt_idx = sidx;
      end
    end
    gnt = req_hit & can_load;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      rr_q    <= '0;
      tag_q   <= '0;
      data_q  <= '0;
      exc_q   <= 1'b0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      exc_q   <= exc_d;
      src_q   <= src_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    tag_d   = tag_q;
    data_d  = data_q;
    exc_d   = exc_q;
    src_d   = src_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else if (gnt) begin
      state_d = FULL;
      tag_d   = bus.fu_tag[int'(gnt_idx)*TAG_W +: TAG_W];
      data_d  = bus.fu_data[int'(gnt_idx)*DATA_W +: DATA_W];
      exc_d   = bus.fu_exc[gnt_idx];
      src_d   = gnt_idx;
      rr_d    = (gnt_idx == SRC_W'(NUM_FU - 1)) ?
                '0 : gnt_idx + 1'b1;
    end else if (state_q == FULL && bus.cdb_ready) begin
      state_d = EMPTY;
    end
  end

  always_comb begin
    fu_ready_d = '0;
    if (gnt && !rst) fu_ready_d[gnt_idx] = 1'b1;
  end

  assign bus.fu_ready  = fu_ready_d;
  assign bus.cdb_valid = (state_q == FULL);
  assign bus.cdb_tag   = tag_q;
  assign bus.cdb_data  = data_q;
  assign bus.cdb_exc   = exc_q;
  assign bus.cdb_src   = src_q;

`ifdef ROB_CDB_PERF_EN
  logic [31:0] stall_q, conf_q;
  logic        stall_ev, conf_ev;

  assign stall_ev = (|bus.fu_valid) & ~gnt;
  assign conf_ev  = ($countones(bus.fu_valid) >= 2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      conf_q  <= '0;
    end else begin
      if (stall_ev && stall_q != 32'hFFFF_FFFF)
        stall_q <= stall_q + 32'd1;
      if (conf_ev && conf_q != 32'hFFFF_FFFF)
        conf_q <= conf_q + 32'd1;
    end
  end

  assign perf_stall_cnt_o    = stall_q;
  assign perf_conflict_cnt_o = conf_q;
`endif
endmodule

// File: tb/tb_rob_cdb_arbiter.sv
// Randomized bench for rob_cdb_arbiter against a queue-free
// behavioural model of the completion bus.
module tb_rob_cdb_arbiter;
  localparam int N  = 4;
  localparam int TW = 5;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;

  rob_cdb_arbiter_if #(.NUM_FU(N), .TAG_W(TW), .DATA_W(DW)) b();

`ifdef ROB_CDB_PERF_EN
  logic [31:0] stall_cnt, conf_cnt;
`endif

  rob_cdb_arbiter #(.NUM_FU(N), .TAG_W(TW), .DATA_W(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .bus     (b)
`ifdef ROB_CDB_PERF_EN
    ,
    .perf_stall_cnt_o    (stall_cnt),
    .perf_conflict_cnt_o (conf_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // FU-side pending completions
  bit          pend [N];
  logic [TW-1:0] ptag [N];
  logic [DW-1:0] pdata [N];
  bit          pexc [N];
  bit          rdy = 1'b1;

  // model of the bus entry
  bit          m_valid;
  int          m_rr;
  logic [TW-1:0] m_tag;
  logic [DW-1:0] m_data;
  bit          m_exc;
  int          m_src;
  longint      m_stall, m_conf;
  int          last_g;

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t",
                  tag, got, exp, $time);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      b.fu_valid[i] = pend[i];
      b.fu_tag[i*TW +: TW] = ptag[i];
      b.fu_data[i*DW +: DW] = pdata[i];
      b.fu_exc[i] = pexc[i];
    end
    b.cdb_ready = rdy;
  endtask

  function automatic int model_grant();
    if (flush) return -1;
    if (m_valid && !rdy) return -1;
    for (int k = 0; k < N; k++)
      if (pend[(m_rr + k) % N]) return (m_rr + k) % N;
    return -1;
  endfunction

  task automatic new_req(int i);
    pend[i]  = 1'b1;
    ptag[i]  = TW'($urandom);
    pdata[i] = {$urandom, $urandom};
    pexc[i]  = ($urandom_range(0, 7) == 0);
  endtask

  // One clock: inputs applied at negedge, checked, model advanced.
  task automatic cycle();
    int g, cnt;
    logic [N-1:0] exp_rdy;
    drive();
    #1;
    g = model_grant();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("fu_ready", 64'(b.fu_ready), 64'(exp_rdy));
    check("cdb_valid", 64'(b.cdb_valid), 64'(m_valid));
    if (m_valid) begin
      check("cdb_tag", 64'(b.cdb_tag), 64'(m_tag));
      check("cdb_data", b.cdb_data, m_data);
      check("cdb_exc", 64'(b.cdb_exc), 64'(m_exc));
      check("cdb_src", 64'(b.cdb_src), 64'(m_src));
    end
`ifdef ROB_CDB_PERF_EN
    check("perf_stall", 64'(stall_cnt), 64'(m_stall));
    check("perf_conf", 64'(conf_cnt), 64'(m_conf));
`endif
    cnt = 0;
    for (int i = 0; i < N; i++) cnt += int'(pend[i]);
    if (cnt >= 1 && g < 0) m_stall++;
    if (cnt >= 2) m_conf++;
    last_g = g;
    @(posedge clk);
    if (flush) begin
      m_valid = 1'b0;
    end else if (g >= 0) begin
      m_valid = 1'b1;
      m_tag = ptag[g];
      m_data = pdata[g];
      m_exc = pexc[g];
      m_src = g;
      m_rr = (g + 1) % N;
      pend[g] = 1'b0;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_rr = 0;
    m_tag = '0; m_data = '0; m_exc = 1'b0; m_src = 0;
    m_stall = 0; m_conf = 0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; ptag[i] = '0;
      pdata[i] = '0; pexc[i] = 1'b0;
    end
    model_reset();
    drive();
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", 64'(b.cdb_valid), 64'd0);
    check("rst_tag", 64'(b.cdb_tag), 64'd0);
    check("rst_data", b.cdb_data, 64'd0);
    check("rst_src", 64'(b.cdb_src), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // single requester
    pend[2] = 1'b1; ptag[2] = 5'd7;
    pdata[2] = 64'hDEAD; pexc[2] = 1'b0;
    cycle();
    check("single_gnt", 64'(last_g), 64'd2);
    cycle();
    check("single_tag", 64'(b.cdb_tag), 64'd7);
    check("single_src", 64'(b.cdb_src), 64'd2);

    // round robin from rr=3 with all FUs held valid
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < N; i++) if (!pend[i]) new_req(i);
      cycle();
      check("rr_order", 64'(last_g), 64'((3 + k) % N));
    end

    // backpressure then release, no bubble
    rdy = 1'b0;
    repeat (3) cycle();
    check("bp_nogrant", 64'(last_g + 1), 64'd0);
    rdy = 1'b1;
    cycle();
    check("bp_reload", 64'(last_g >= 0), 64'd1);

    // flush while full
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    new_req(0); new_req(1);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check("flush_gone", 64'(b.cdb_valid), 64'd0);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 2) == 0) new_req(i);
      rdy = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 15) == 0);
      cycle();
      if (flush)
        for (int i = 0; i < N; i++)
          if ($urandom_range(0, 1) == 0) pend[i] = 1'b0;
    end
    flush = 1'b0;

    // async reset mid-cycle while full
    rdy = 1'b0;
    new_req(1);
    cycle();
    cycle();
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 64'(b.cdb_valid), 64'd0);
    check("arst_ready", 64'(b.fu_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    rdy = 1'b1;
    for (int i = 0; i < N; i++) new_req(i);
    cycle();
    check("arst_rr0", 64'(last_g), 64'd0);
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
